pc_sequencer: RTL and testbench

Program-counter sequencer and redirect controller for the fetch stage. It holds the architectural PC, issues fetch requests to instruction memory under a valid/ready handshake, and applies taken jump/branch targets resolved by the execute-stage jump/branch unit. On each applied redirect it flushes wrong-path work in IF/ID for a fixed number of cycles. It sits between the execute stage, the hazard unit and the instruction-memory port.

---
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: holds the PC, drives the instruction-memory
// request handshake and applies resolved jump/branch redirects with a timed IF/ID flush.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_ADDR   = '0,
    parameter int              PC_INCREMENT = 4,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic            redirect_taken,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc,
    output logic            flush_if,
    output logic            flush_id,
    output logic            misaligned,
    output logic [XLEN-1:0] misaligned_addr
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(PC_INCREMENT);
    localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t     state;
    logic [3:0] flush_cnt;

    logic redirect_hit;
    logic target_aligned;
    logic redirect_apply;
    logic redirect_misaligned;
    logic fetch_accept;

    assign redirect_hit        = redirect_valid & redirect_taken;
    assign target_aligned      = (redirect_target[1:0] == 2'b00);
    assign redirect_apply      = redirect_hit & target_aligned;
    assign redirect_misaligned = redirect_hit & ~target_aligned;

    // The request drops in the same cycle the hazard unit stalls, so no fetch slips through.
    assign imem_req     = (state == ST_FETCH) & ~stall;
    assign imem_addr    = pc;
    assign flush_if     = (state == ST_FLUSH);
    assign flush_id     = (state == ST_FLUSH);
    assign fetch_accept = imem_req & imem_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_BOOT;
            pc              <= RESET_ADDR;
            flush_cnt       <= 4'd0;
            misaligned      <= 1'b0;
            misaligned_addr <= '0;
        end else begin
            misaligned <= redirect_misaligned;
            if (redirect_misaligned) begin
                misaligned_addr <= redirect_target;
            end

            // A taken, aligned redirect wins over stall, an accepted fetch and an active flush.
            if (redirect_apply) begin
                pc        <= redirect_target;
                flush_cnt <= FLUSH_LOAD;
                state     <= ST_FLUSH;
            end else begin
                case (state)
                    ST_BOOT: begin
                        state <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (fetch_accept) begin
                            pc <= pc + PC_STEP;
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_cnt <= 4'd1) begin
                            flush_cnt <= 4'd0;
                            state     <= ST_FETCH;
                        end else begin
                            flush_cnt <= flush_cnt - 4'd1;
                        end
                    end
                    default: begin
                        state     <= ST_BOOT;
                        flush_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a cycle-level behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic        redirect_taken;
    logic [31:0] redirect_target;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        flush_if;
    logic        flush_id;
    logic        misaligned;
    logic [31:0] misaligned_addr;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .XLEN(32),
        .RESET_ADDR(32'h0),
        .PC_INCREMENT(4),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_taken(redirect_taken),
        .redirect_target(redirect_target),
        .imem_ready(imem_ready),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .pc(pc),
        .flush_if(flush_if),
        .flush_id(flush_id),
        .misaligned(misaligned),
        .misaligned_addr(misaligned_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic        rt;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_flush;
        logic        e_mis;
        logic [31:0] e_maddr;
    } vec_t;

    function automatic vec_t mk(logic st, logic rv, logic rt, logic [31:0] tgt, logic rdy,
                                logic req, logic [31:0] addr, logic fl, logic mis,
                                logic [31:0] maddr);
        vec_t v;
        v.stall = st; v.rv = rv; v.rt = rt; v.tgt = tgt; v.rdy = rdy;
        v.e_req = req; v.e_addr = addr; v.e_flush = fl; v.e_mis = mis; v.e_maddr = maddr;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string tag, logic req, logic [31:0] addr, logic fl,
                                 logic mis, logic [31:0] maddr);
        chk({tag, " imem_req"},  32'(imem_req),   32'(req));
        chk({tag, " imem_addr"}, imem_addr,       addr);
        chk({tag, " pc"},        pc,              addr);
        chk({tag, " flush_if"},  32'(flush_if),   32'(fl));
        chk({tag, " flush_id"},  32'(flush_id),   32'(fl));
        chk({tag, " misaligned"}, 32'(misaligned), 32'(mis));
        chk({tag, " mis_addr"},  misaligned_addr, maddr);
    endtask

    // Drive one cycle of inputs, compare mid-cycle, then step past the next rising edge.
    task automatic run_vec(string tag, vec_t v);
        stall = v.stall; redirect_valid = v.rv; redirect_taken = v.rt;
        redirect_target = v.tgt; imem_ready = v.rdy;
        #2;
        check_outputs(tag, v.e_req, v.e_addr, v.e_flush, v.e_mis, v.e_maddr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_taken = 1'b0;
        redirect_target = 32'h0; imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Behavioural model: what the fetch stage should be doing, in plain terms.
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_booting;
    logic        m_mis;
    logic [31:0] m_maddr;

    task automatic model_reset();
        m_pc = 32'h0; m_flush_left = 0; m_booting = 1'b1; m_mis = 1'b0; m_maddr = 32'h0;
    endtask

    function automatic logic model_req(logic st);
        return !m_booting && (m_flush_left == 0) && !st;
    endfunction

    task automatic model_step(logic rst_n, logic st, logic rv, logic rt, logic [31:0] tgt,
                              logic rdy);
        bit taken_ok;
        bit taken_bad;
        bit accepted;
        if (!rst_n) begin
            model_reset();
            return;
        end
        taken_ok  = rv && rt && (tgt % 4 == 0);
        taken_bad = rv && rt && (tgt % 4 != 0);
        accepted  = model_req(st) && rdy;
        m_mis = taken_bad;
        if (taken_bad) m_maddr = tgt;
        if (taken_ok) begin
            m_pc = tgt;
            m_flush_left = 2;
            m_booting = 1'b0;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (accepted) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    vec_t tbl[15];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(0,0,0,32'h0,1,        0,32'h0,0,0,32'h0);
        tbl[1]  = mk(0,0,0,32'h0,1,        1,32'h0,0,0,32'h0);
        tbl[2]  = mk(0,0,0,32'h0,1,        1,32'h4,0,0,32'h0);
        tbl[3]  = mk(0,0,0,32'h0,1,        1,32'h8,0,0,32'h0);
        tbl[4]  = mk(0,0,0,32'h0,1,        1,32'hC,0,0,32'h0);
        tbl[5]  = mk(0,1,1,32'h100,1,      1,32'h10,0,0,32'h0);
        tbl[6]  = mk(0,0,0,32'h0,1,        0,32'h100,1,0,32'h0);
        tbl[7]  = mk(0,0,0,32'h0,1,        0,32'h100,1,0,32'h0);
        tbl[8]  = mk(0,0,0,32'h0,1,        1,32'h100,0,0,32'h0);
        tbl[9]  = mk(0,0,0,32'h0,1,        1,32'h104,0,0,32'h0);
        tbl[10] = mk(0,1,1,32'h102,1,      1,32'h108,0,0,32'h0);
        tbl[11] = mk(0,0,0,32'h0,1,        1,32'h10C,0,1,32'h102);
        tbl[12] = mk(0,0,0,32'h0,1,        1,32'h110,0,0,32'h102);
        tbl[13] = mk(0,1,0,32'h400,1,      1,32'h114,0,0,32'h102);
        tbl[14] = mk(0,0,0,32'h0,1,        1,32'h118,0,0,32'h102);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i]);
        end

        // Stall and not-ready hold the PC; a redirect still lands during stall.
        do_reset();
        run_vec("hold boot",    mk(0,0,0,32'h0,0,  0,32'h0,0,0,32'h0));
        run_vec("hold redir",   mk(0,1,1,32'h20,0, 1,32'h0,0,0,32'h0));
        run_vec("hold fl1",     mk(0,0,0,32'h0,0,  0,32'h20,1,0,32'h0));
        run_vec("hold fl2",     mk(0,0,0,32'h0,0,  0,32'h20,1,0,32'h0));
        for (int i = 0; i < 3; i++) run_vec("hold stall", mk(1,0,0,32'h0,1, 0,32'h20,0,0,32'h0));
        for (int i = 0; i < 2; i++) run_vec("hold nrdy",  mk(0,0,0,32'h0,0, 1,32'h20,0,0,32'h0));
        run_vec("hold accept",  mk(0,0,0,32'h0,1,  1,32'h20,0,0,32'h0));
        run_vec("stall redir",  mk(1,1,1,32'h40,1, 0,32'h24,0,0,32'h0));
        run_vec("stall fl1",    mk(1,0,0,32'h0,1,  0,32'h40,1,0,32'h0));
        run_vec("stall fl2",    mk(0,0,0,32'h0,1,  0,32'h40,1,0,32'h0));

        // Second redirect during flush restarts the flush window.
        run_vec("dbl r1",       mk(0,1,1,32'h200,1, 1,32'h40,0,0,32'h0));
        run_vec("dbl r2",       mk(0,1,1,32'h300,1, 0,32'h200,1,0,32'h0));
        run_vec("dbl fl1",      mk(0,0,0,32'h0,1,   0,32'h300,1,0,32'h0));
        run_vec("dbl fl2",      mk(0,0,0,32'h0,1,   0,32'h300,1,0,32'h0));
        run_vec("dbl fetch",    mk(0,0,0,32'h0,1,   1,32'h300,0,0,32'h0));
        run_vec("dbl next",     mk(0,0,0,32'h0,1,   1,32'h304,0,0,32'h0));

        // PC wraps from the top of the address space.
        run_vec("wrap redir",   mk(0,1,1,32'hFFFF_FFFC,1, 1,32'h308,0,0,32'h0));
        run_vec("wrap fl1",     mk(0,0,0,32'h0,1, 0,32'hFFFF_FFFC,1,0,32'h0));
        run_vec("wrap fl2",     mk(0,0,0,32'h0,1, 0,32'hFFFF_FFFC,1,0,32'h0));
        run_vec("wrap top",     mk(0,0,0,32'h0,1, 1,32'hFFFF_FFFC,0,0,32'h0));
        run_vec("wrap zero",    mk(0,0,0,32'h0,1, 1,32'h0,0,0,32'h0));

        // Reset in the middle of a flush, with a captured misaligned address pending.
        run_vec("rst misal",    mk(0,1,1,32'h777,1, 1,32'h4,0,0,32'h0));
        run_vec("rst redir",    mk(0,1,1,32'h500,1, 1,32'h8,0,1,32'h777));
        reset_n = 1'b0;
        run_vec("rst in flush", mk(0,0,0,32'h0,1, 0,32'h500,1,0,32'h777));
        run_vec("rst values",   mk(0,0,0,32'h0,1, 0,32'h0,0,0,32'h0));
        reset_n = 1'b1;
        run_vec("rst boot",     mk(0,0,0,32'h0,1, 0,32'h0,0,0,32'h0));
        run_vec("rst first",    mk(0,0,0,32'h0,1, 1,32'h0,0,0,32'h0));

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) t = t & 32'h0000_03FF;
            reset_n         = ($urandom_range(0, 63) != 0);
            stall           = ($urandom_range(0, 3) == 0);
            redirect_valid  = ($urandom_range(0, 5) == 0);
            redirect_taken  = ($urandom_range(0, 3) != 0);
            redirect_target = t;
            imem_ready      = ($urandom_range(0, 2) != 0);
            #2;
            check_outputs("rand", model_req(stall), m_pc, (m_flush_left > 0), m_mis, m_maddr);
            @(posedge clk);
            model_step(reset_n, stall, redirect_valid, redirect_taken, redirect_target,
                       imem_ready);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
